cpu_trace_buffer: RTL and testbench

Parametrised execution-trace capture unit for the single-cycle CPU core. Each cycle it samples the core's PC, instruction, ALU result, flags and control strobes into a circular buffer of configurable depth, in one of three capture modes: fill, wrap or PC-trigger with post-trigger count. After capture it drains the buffer oldest-first over a valid/ready stream. It replaces per-cycle register/RAM printouts with in-system observability, and it sits beside the core, tapping its datapath signals read-only.

---
 rtl/cpu_trace_buffer.sv | 160 ++++++++++++++++
 tb/tb_cpu_trace_buffer.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_buffer.sv
// Execution-trace capture unit: samples core taps into a circular buffer in
// FILL, WRAP or PC-trigger mode, then drains oldest-first over valid/ready.
module cpu_trace_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int POST   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     cap_en,
  input  logic [1:0]               mode,
  input  logic [DATA_W-1:0]        trig_pc,
  input  logic [DATA_W-1:0]        cpu_pc,
  input  logic [DATA_W-1:0]        cpu_instr,
  input  logic [DATA_W-1:0]        cpu_alu,
  input  logic [3:0]               cpu_flags,
  input  logic                     cpu_regwrite,
  input  logic                     cpu_memwrite,
  input  logic                     cpu_pcsrc,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [DATA_W-1:0]        rd_pc,
  output logic [DATA_W-1:0]        rd_instr,
  output logic [DATA_W-1:0]        rd_alu,
  output logic [6:0]               rd_ctrl,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     triggered,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 3 * DATA_W + 7;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_POST, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      mode_q, mode_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   post_cnt_q, post_cnt_d;
  logic            triggered_q, triggered_d;
  logic            overflow_q, overflow_d;
  logic            busy_q, busy_d;
  logic            sample;

  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   rptr;
  logic [DATA_W-1:0] e_pc, e_instr, e_alu;
  logic [6:0]      e_ctrl;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    wptr_d      = wptr_q;
    count_d     = count_q;
    post_cnt_d  = post_cnt_q;
    triggered_d = triggered_q;
    overflow_d  = overflow_q;
    sample      = 1'b0;
    if (clr) begin
      state_d     = S_IDLE;
      wptr_d      = '0;
      count_d     = '0;
      triggered_d = 1'b0;
      overflow_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cap_en) begin
            state_d     = S_CAPTURE;
            mode_d      = mode;
            wptr_d      = '0;
            count_d     = '0;
            triggered_d = 1'b0;
            overflow_d  = 1'b0;
          end
        end
        S_CAPTURE: begin
          if (!cap_en) begin
            state_d = S_DONE;
          end else begin
            sample = 1'b1;
            if (mode_q == 2'd2) begin
              // The trigger sample itself counts as the first of POST entries
              if (cpu_pc == trig_pc) begin
                triggered_d = 1'b1;
                post_cnt_d  = CW'(POST - 1);
                state_d     = (POST == 1) ? S_DONE : S_POST;
              end
            end else if (mode_q != 2'd1) begin
              if (count_q == CW'(DEPTH - 1)) state_d = S_DONE;
            end
          end
        end
        S_POST: begin
          sample     = 1'b1;
          post_cnt_d = post_cnt_q - CW'(1);
          if (post_cnt_q == CW'(1)) state_d = S_DONE;
        end
        S_DONE: begin
          if (count_q == '0) state_d = S_IDLE;
          else if (rd_ready) count_d = count_q - CW'(1);
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (sample) begin
      wptr_d = wptr_q + AW'(1);
      if (count_q == CW'(DEPTH)) overflow_d = 1'b1;
      else count_d = count_q + CW'(1);
    end
    busy_d = (state_d == S_CAPTURE) || (state_d == S_POST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mode_q      <= 2'd0;
      wptr_q      <= '0;
      count_q     <= '0;
      post_cnt_q  <= '0;
      triggered_q <= 1'b0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      wptr_q      <= wptr_d;
      count_q     <= count_d;
      post_cnt_q  <= post_cnt_d;
      triggered_q <= triggered_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
    end
  end

  // Trace storage is deliberately unreset; only pointers qualify its contents
  always_ff @(posedge clk) begin
    if (sample)
      mem[wptr_q] <= {cpu_pc, cpu_instr, cpu_alu, cpu_flags,
                      cpu_regwrite, cpu_memwrite, cpu_pcsrc};
  end

  assign rptr = wptr_q - count_q[AW-1:0];
  assign {e_pc, e_instr, e_alu, e_ctrl} = mem[rptr];

  assign rd_valid  = (state_q == S_DONE) && (count_q != '0);
  assign rd_pc     = rd_valid ? e_pc    : '0;
  assign rd_instr  = rd_valid ? e_instr : '0;
  assign rd_alu    = rd_valid ? e_alu   : '0;
  assign rd_ctrl   = rd_valid ? e_ctrl  : '0;
  assign count     = count_q;
  assign busy      = busy_q;
  assign triggered = triggered_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer: randomized core taps against a
// queue model holding the last DEPTH captured entries.
module tb_cpu_trace_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int POST  = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] instr;
    logic [DW-1:0] alu;
    logic [6:0]    ctrl;
  } entry_t;

  logic clk = 1'b0, rst_n = 1'b1, clr = 1'b0, cap_en = 1'b0, rd_ready = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [DW-1:0] trig_pc = '0, cpu_pc = '0, cpu_instr = '0, cpu_alu = '0;
  logic [3:0] cpu_flags = '0;
  logic cpu_regwrite = 1'b0, cpu_memwrite = 1'b0, cpu_pcsrc = 1'b0;

  logic rd_valid, busy, triggered, overflow;
  logic [DW-1:0] rd_pc, rd_instr, rd_alu;
  logic [6:0] rd_ctrl;
  logic [CW-1:0] count;

  logic rd_valid2, busy2, triggered2, overflow2;
  logic [DW-1:0] rd_pc2, rd_instr2, rd_alu2;
  logic [6:0] rd_ctrl2;
  logic [CW-1:0] count2;

  int tests_run = 0;
  int failed = 0;
  entry_t exp_q[$];
  logic model_ovf;

  cpu_trace_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .POST(POST)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .cap_en(cap_en), .mode(mode),
    .trig_pc(trig_pc), .cpu_pc(cpu_pc), .cpu_instr(cpu_instr), .cpu_alu(cpu_alu),
    .cpu_flags(cpu_flags), .cpu_regwrite(cpu_regwrite), .cpu_memwrite(cpu_memwrite),
    .cpu_pcsrc(cpu_pcsrc), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc),
    .rd_instr(rd_instr), .rd_alu(rd_alu), .rd_ctrl(rd_ctrl), .count(count),
    .busy(busy), .triggered(triggered), .overflow(overflow));

  // Second instance with a single post-trigger entry shares all inputs
  cpu_trace_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .POST(1)) dut_p1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .cap_en(cap_en), .mode(mode),
    .trig_pc(trig_pc), .cpu_pc(cpu_pc), .cpu_instr(cpu_instr), .cpu_alu(cpu_alu),
    .cpu_flags(cpu_flags), .cpu_regwrite(cpu_regwrite), .cpu_memwrite(cpu_memwrite),
    .cpu_pcsrc(cpu_pcsrc), .rd_valid(rd_valid2), .rd_ready(rd_ready), .rd_pc(rd_pc2),
    .rd_instr(rd_instr2), .rd_alu(rd_alu2), .rd_ctrl(rd_ctrl2), .count(count2),
    .busy(busy2), .triggered(triggered2), .overflow(overflow2));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [DW-1:0] pc);
    cpu_pc    = pc;
    cpu_instr = $urandom;
    cpu_alu   = $urandom;
    {cpu_flags, cpu_regwrite, cpu_memwrite, cpu_pcsrc} = 7'($urandom);
  endtask

  task automatic model_push();
    entry_t e;
    e = {cpu_pc, cpu_instr, cpu_alu, cpu_flags, cpu_regwrite, cpu_memwrite, cpu_pcsrc};
    exp_q.push_back(e);
    if (exp_q.size() > DEPTH) begin
      void'(exp_q.pop_front());
      model_ovf = 1'b1;
    end
  endtask

  task automatic arm(input logic [1:0] m);
    mode = m;
    cap_en = 1'b1;
    exp_q.delete();
    model_ovf = 1'b0;
    tick();
    tests_run++;
    if (busy !== 1'b1 || count !== '0 || overflow !== 1'b0 || triggered !== 1'b0) begin
      failed++;
      $display("[TB] FAIL arm: busy=%b count=%0d ovf=%b trig=%b, want 1 0 0 0",
               busy, count, overflow, triggered);
    end
  endtask

  // pat 0: always ready, 1: ready 1,0,0 repeating, 2: random ready
  task automatic drain(input string name, input int pat);
    int cyc = 0;
    int n0 = exp_q.size();
    entry_t got;
    cap_en = 1'b0;
    while (exp_q.size() > 0 && cyc < 200) begin
      got = {rd_pc, rd_instr, rd_alu, rd_ctrl};
      tests_run++;
      if (rd_valid !== 1'b1 || count !== CW'(exp_q.size())) begin
        failed++;
        $display("[TB] FAIL %s drain status: valid=%b count=%0d, want 1 %0d",
                 name, rd_valid, count, exp_q.size());
      end
      tests_run++;
      if (got !== exp_q[0]) begin
        failed++;
        $display("[TB] FAIL %s drain entry: got %h want %h", name, got, exp_q[0]);
      end
      rd_ready = (pat == 0) ? 1'b1 : (pat == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      tick();
      if (rd_ready) void'(exp_q.pop_front());
      cyc++;
    end
    rd_ready = 1'b0;
    tests_run++;
    if (exp_q.size() != 0 || (pat == 0 && cyc != n0)) begin
      failed++;
      $display("[TB] FAIL %s drain length: %0d beats, %0d left, want %0d beats",
               name, cyc, exp_q.size(), n0);
    end
    tests_run++;
    if (rd_valid !== 1'b0 || count !== '0 || rd_pc !== '0) begin
      failed++;
      $display("[TB] FAIL %s drain end: valid=%b count=%0d pc=%h, want 0 0 0",
               name, rd_valid, count, rd_pc);
    end
    exp_q.delete();
    tick();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    tests_run++;
    if (rd_valid !== 1'b0 || count !== '0 || busy !== 1'b0 || triggered !== 1'b0 ||
        overflow !== 1'b0 || rd_pc !== '0 || rd_ctrl !== '0) begin
      failed++;
      $display("[TB] FAIL reset: valid=%b count=%0d busy=%b trig=%b ovf=%b pc=%h",
               rd_valid, count, busy, triggered, overflow, rd_pc);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    arm(2'd0);
    for (int i = 0; i < 20; i++) begin
      drive(DW'(i * 4));
      if (exp_q.size() < DEPTH) model_push();
      tick();
    end
    tests_run++;
    if (busy !== 1'b0 || count !== CW'(DEPTH) || overflow !== 1'b0 || rd_pc !== '0) begin
      failed++;
      $display("[TB] FAIL fill done: busy=%b count=%0d ovf=%b pc=%h, want 0 16 0 0",
               busy, count, overflow, rd_pc);
    end
    drain("fill", 0);
  endtask

  task automatic test_wrap();
    arm(2'd1);
    for (int i = 0; i < 20; i++) begin
      drive(DW'(i * 4));
      model_push();
      tick();
    end
    cap_en = 1'b0;
    tick();
    tests_run++;
    if (busy !== 1'b0 || count !== CW'(DEPTH) || overflow !== model_ovf || rd_pc !== 32'd16) begin
      failed++;
      $display("[TB] FAIL wrap done: busy=%b count=%0d ovf=%b pc=%0d, want 0 16 1 16",
               busy, count, overflow, rd_pc);
    end
    drain("wrap", 2);
  endtask

  task automatic run_trig(input string name, input int trig_at, input int reinject);
    int post_left = -1;
    logic [DW-1:0] pc;
    arm(2'd2);
    for (int i = 0; i < 60; i++) begin
      if (trig_at < 0) pc = DW'(i * 4);
      else if (i == trig_at || (post_left == reinject)) pc = trig_pc;
      else pc = $urandom | 32'h1;
      drive(pc);
      if (post_left < 0) begin
        model_push();
        if (pc == trig_pc) post_left = POST - 1;
      end else if (post_left > 0) begin
        model_push();
        post_left--;
      end
      tick();
      if (post_left == POST - 1) begin
        tests_run++;
        if (triggered !== 1'b1 || busy !== 1'b1) begin
          failed++;
          $display("[TB] FAIL %s trigger edge: trig=%b busy=%b, want 1 1", name, triggered, busy);
        end
      end
      if (post_left == 0) break;
    end
    for (int i = 0; i < 3; i++) begin
      drive(trig_pc);
      tick();
    end
    tests_run++;
    if (busy !== 1'b0 || triggered !== 1'b1 || overflow !== model_ovf ||
        count !== CW'(exp_q.size())) begin
      failed++;
      $display("[TB] FAIL %s done: busy=%b trig=%b ovf=%b count=%0d, want 0 1 %b %0d",
               name, busy, triggered, overflow, count, model_ovf, exp_q.size());
    end
  endtask

  task automatic test_trig();
    trig_pc = 32'd40;
    run_trig("trig", -1, -9);
    tests_run++;
    if (rd_pc !== 32'd8 || count !== CW'(16)) begin
      failed++;
      $display("[TB] FAIL trig oldest: pc=%0d count=%0d, want 8 16", rd_pc, count);
    end
    drain("trig", 0);
  endtask

  task automatic test_trig_random();
    for (int r = 0; r < 3; r++) begin
      trig_pc = 32'hDEAD_BEE0;
      run_trig("trig_rand", int'($urandom_range(0, 25)), int'($urandom_range(1, POST - 2)));
      drain("trig_rand", 2);
    end
  endtask

  task automatic test_back_to_back();
    arm(2'd1);
    for (int i = 0; i < 10; i++) begin
      drive($urandom);
      model_push();
      tick();
    end
    cap_en = 1'b0;
    tick();
    tests_run++;
    if (count !== CW'(10) || overflow !== 1'b0 || rd_valid !== 1'b1) begin
      failed++;
      $display("[TB] FAIL backpressure start: count=%0d ovf=%b valid=%b, want 10 0 1",
               count, overflow, rd_valid);
    end
    drain("backpressure", 1);
  endtask

  task automatic test_mode3();
    arm(2'd3);
    for (int i = 0; i < 20; i++) begin
      drive($urandom);
      if (exp_q.size() < DEPTH) model_push();
      tick();
    end
    tests_run++;
    if (busy !== 1'b0 || count !== CW'(DEPTH) || overflow !== 1'b0) begin
      failed++;
      $display("[TB] FAIL mode3: busy=%b count=%0d ovf=%b, want 0 16 0", busy, count, overflow);
    end
    drain("mode3", 2);
  endtask

  task automatic test_cap_drop();
    trig_pc = 32'hDEAD_BEE0;
    arm(2'd2);
    cap_en = 1'b0;
    drive($urandom | 32'h1);
    tick();
    tests_run++;
    if (busy !== 1'b0 || count !== '0 || triggered !== 1'b0 || rd_valid !== 1'b0) begin
      failed++;
      $display("[TB] FAIL cap_drop: busy=%b count=%0d trig=%b valid=%b, want 0 0 0 0",
               busy, count, triggered, rd_valid);
    end
    cap_en = 1'b1;
    mode = 2'd1;
    tick();
    tests_run++;
    if (busy !== 1'b0) begin
      failed++;
      $display("[TB] FAIL cap_drop done_to_idle: busy=%b, want 0", busy);
    end
    tick();
    tests_run++;
    if (busy !== 1'b1) begin
      failed++;
      $display("[TB] FAIL cap_drop rearm: busy=%b, want 1", busy);
    end
    cap_en = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_clear();
    arm(2'd1);
    for (int i = 0; i < 10; i++) begin
      drive($urandom);
      tick();
    end
    cap_en = 1'b0;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tests_run++;
    if (count !== '0 || rd_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
      failed++;
      $display("[TB] FAIL clear: count=%0d valid=%b busy=%b ovf=%b, want 0 0 0 0",
               count, rd_valid, busy, overflow);
    end
    cap_en = 1'b1;
    tick();
    tests_run++;
    if (busy !== 1'b1) begin
      failed++;
      $display("[TB] FAIL clear idle rearm: busy=%b, want 1", busy);
    end
    cap_en = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_post1();
    logic [DW-1:0] first_pc;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    trig_pc = 32'hDEAD_BEE0;
    mode = 2'd2;
    cap_en = 1'b1;
    tick();
    first_pc = $urandom | 32'h1;
    drive(first_pc);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive($urandom | 32'h1);
      tick();
    end
    drive(trig_pc);
    tick();
    tests_run++;
    if (busy2 !== 1'b0 || triggered2 !== 1'b1 || count2 !== CW'(4) || busy !== 1'b1) begin
      failed++;
      $display("[TB] FAIL post1: busy=%b trig=%b count=%0d main_busy=%b, want 0 1 4 1",
               busy2, triggered2, count2, busy);
    end
    tests_run++;
    if (rd_valid2 !== 1'b1 || rd_pc2 !== first_pc) begin
      failed++;
      $display("[TB] FAIL post1 oldest: valid=%b pc=%h, want 1 %h", rd_valid2, rd_pc2, first_pc);
    end
    cap_en = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    arm(2'd1);
    for (int i = 0; i < 5; i++) begin
      drive($urandom);
      tick();
    end
    tests_run++;
    if (count !== CW'(5) || busy !== 1'b1) begin
      failed++;
      $display("[TB] FAIL reset_mid pre: count=%0d busy=%b, want 5 1", count, busy);
    end
    cap_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (count !== '0 || busy !== 1'b0 || rd_valid !== 1'b0 || triggered !== 1'b0 ||
        overflow !== 1'b0 || rd_pc !== '0) begin
      failed++;
      $display("[TB] FAIL reset_mid: count=%0d busy=%b valid=%b trig=%b ovf=%b pc=%h",
               count, busy, rd_valid, triggered, overflow, rd_pc);
    end
    #1 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_wrap();
    test_trig();
    test_trig_random();
    test_back_to_back();
    test_mode3();
    test_cap_drop();
    test_clear();
    test_post1();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
